// File: rtl/gpio_lb_pkg.sv
// Shared types for the GPIO loopback / fault-injection model.
// Mode encodings match the 2-bit inj_mode pin values.
package gpio_lb_pkg;

  typedef enum logic [1:0] {
    INJ_NONE    = 2'd0,
    INJ_ONESHOT = 2'd1,
    INJ_BURST   = 2'd2,
    INJ_CONT    = 2'd3
  } inj_mode_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } inj_state_e;

endpackage

// File: rtl/gpio_delay_line.sv
// Free-running GPIO shift register with a clamped, live-selectable tap.
// The tap re-selects immediately on a delay_sel change; the stages never stall or flush.
module gpio_delay_line #(
  parameter int WIDTH     = 17,
  parameter int MAX_DELAY = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [WIDTH-1:0]               din,
  input  logic [$clog2(MAX_DELAY+1)-1:0] delay_sel,
  output logic [WIDTH-1:0]               raw
);

  localparam int SEL_W = $clog2(MAX_DELAY + 1);

  logic [WIDTH-1:0] stage [MAX_DELAY];
  logic [SEL_W-1:0] tap;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < MAX_DELAY; k++) stage[k] <= '0;
    end else begin
      stage[0] <= din;
      for (int unsigned k = 1; k < MAX_DELAY; k++) stage[k] <= stage[k-1];
    end
  end

  // A select of 0 behaves as 1; anything past the deepest stage uses the deepest stage.
  always_comb begin
    if (delay_sel == '0)
      tap = SEL_W'(1);
    else if (delay_sel > SEL_W'(MAX_DELAY))
      tap = SEL_W'(MAX_DELAY);
    else
      tap = delay_sel;
    raw = '0;
    for (int unsigned k = 0; k < MAX_DELAY; k++) begin
      if (tap == SEL_W'(k + 1)) raw = stage[k];
    end
  end

endmodule

// File: rtl/gpio_loopback_inject.sv
// GPIO loopback with programmable delay and mask-based fault injection
// (one-shot, burst or continuous), plus a saturating corrupted-cycle counter.
module gpio_loopback_inject
  import gpio_lb_pkg::*;
#(
  parameter int WIDTH     = 17,
  parameter int MAX_DELAY = 4,
  parameter int LEN_W     = 8,
  parameter int CNT_W     = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [WIDTH-1:0]               GPIO_OUT,
  output logic [WIDTH-1:0]               GPIO_IN,
  input  logic [$clog2(MAX_DELAY+1)-1:0] delay_sel,
  input  logic [1:0]                     inj_mode,
  input  logic [WIDTH-1:0]               inj_mask,
  input  logic [LEN_W-1:0]               inj_len,
  input  logic                           inj_start,
  input  logic                           clr_count,
  output logic                           inj_busy,
  output logic [CNT_W-1:0]               inj_count
);

  inj_state_e       state_q, state_d;
  inj_mode_e        mode_q, mode_d, mode_in;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [WIDTH-1:0] raw;
  logic [CNT_W-1:0] count_q;

  assign mode_in = inj_mode_e'(inj_mode);

  gpio_delay_line #(
    .WIDTH    (WIDTH),
    .MAX_DELAY(MAX_DELAY)
  ) u_delay (
    .clk      (clk),
    .reset_n  (reset_n),
    .din      (GPIO_OUT),
    .delay_sel(delay_sel),
    .raw      (raw)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      mode_q      <= INJ_NONE;
      mask_q      <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      mask_q      <= mask_d;
      remaining_q <= remaining_d;
    end
  end

  // Abort on a NONE mode input takes priority over the burst countdown.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    mask_d      = mask_q;
    remaining_d = remaining_q;
    case (state_q)
      IDLE: begin
        if (inj_start && mode_in != INJ_NONE) begin
          state_d = ACTIVE;
          mode_d  = mode_in;
          mask_d  = inj_mask;
          case (mode_in)
            INJ_ONESHOT: remaining_d = LEN_W'(1);
            INJ_BURST:   remaining_d = (inj_len == '0) ? LEN_W'(1) : inj_len;
            default:     remaining_d = '0;
          endcase
        end
      end
      ACTIVE: begin
        if (mode_in == INJ_NONE) begin
          state_d     = IDLE;
          remaining_d = '0;
        end else if (mode_q != INJ_CONT) begin
          if (remaining_q == LEN_W'(1)) state_d = IDLE;
          remaining_d = remaining_q - LEN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign inj_busy = (state_q == ACTIVE);
  assign GPIO_IN  = raw ^ (inj_busy ? mask_q : '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clr_count) begin
      count_q <= '0;
    end else if (inj_busy && mask_q != '0 && count_q != '1) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign inj_count = count_q;

endmodule

// File: tb/tb_gpio_loopback_inject.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized
// traffic, all compared every cycle against a history/countdown reference model.
module tb_gpio_loopback_inject;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [16:0] GPIO_OUT;
  logic [16:0] gpio_in16, gpio_in4;
  logic [2:0]  delay_sel;
  logic [1:0]  inj_mode;
  logic [16:0] inj_mask;
  logic [7:0]  inj_len;
  logic        inj_start;
  logic        clr_count;
  logic        busy16, busy4;
  logic [15:0] count16;
  logic [3:0]  count4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpio_loopback_inject #(
    .WIDTH(17), .MAX_DELAY(4), .LEN_W(8), .CNT_W(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .GPIO_OUT(GPIO_OUT), .GPIO_IN(gpio_in16),
    .delay_sel(delay_sel), .inj_mode(inj_mode), .inj_mask(inj_mask), .inj_len(inj_len),
    .inj_start(inj_start), .clr_count(clr_count), .inj_busy(busy16), .inj_count(count16)
  );

  gpio_loopback_inject #(
    .WIDTH(17), .MAX_DELAY(4), .LEN_W(8), .CNT_W(4)
  ) dut4 (
    .clk(clk), .reset_n(reset_n), .GPIO_OUT(GPIO_OUT), .GPIO_IN(gpio_in4),
    .delay_sel(delay_sel), .inj_mode(inj_mode), .inj_mask(inj_mask), .inj_len(inj_len),
    .inj_start(inj_start), .clr_count(clr_count), .inj_busy(busy4), .inj_count(count4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: history of sampled GPIO_OUT values, plus a count of
  // corrupted cycles still owed (-1 = unlimited) and two saturating counters.
  logic [16:0] m_hist [4];
  bit          m_active = 1'b0;
  logic [16:0] m_mask = '0;
  int          m_left = 0;
  int          m_cnt16 = 0;
  int          m_cnt4 = 0;

  function automatic int clamp_delay(input logic [2:0] ds);
    if (ds == 3'd0) return 1;
    if (ds > 3'd4) return 4;
    return int'(ds);
  endfunction

  always @(posedge clk) begin
    logic [16:0] exp_in;
    if (!reset_n) begin
      for (int k = 0; k < 4; k++) m_hist[k] = '0;
      m_active = 1'b0;
      m_mask   = '0;
      m_left   = 0;
      m_cnt16  = 0;
      m_cnt4   = 0;
    end else begin
      if (clr_count) begin
        m_cnt16 = 0;
        m_cnt4  = 0;
      end else if (m_active && m_mask != '0) begin
        if (m_cnt16 < 65535) m_cnt16++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      if (m_active) begin
        if (inj_mode == 2'd0) m_active = 1'b0;
        else if (m_left > 0) begin
          m_left--;
          if (m_left == 0) m_active = 1'b0;
        end
      end else if (inj_start && inj_mode != 2'd0) begin
        m_active = 1'b1;
        m_mask   = inj_mask;
        if (inj_mode == 2'd1) m_left = 1;
        else if (inj_mode == 2'd2) m_left = (inj_len == 8'd0) ? 1 : int'(inj_len);
        else m_left = -1;
      end
      for (int k = 3; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = GPIO_OUT;
    end
    #1;
    exp_in = m_hist[clamp_delay(delay_sel) - 1] ^ (m_active ? m_mask : 17'h0);
    check("model_gpio_in",    32'(gpio_in16), 32'(exp_in));
    check("model_gpio_in_c4", 32'(gpio_in4),  32'(exp_in));
    check("model_busy",       32'(busy16),    32'(m_active));
    check("model_busy_c4",    32'(busy4),     32'(m_active));
    check("model_count",      32'(count16),   32'(m_cnt16));
    check("model_count_c4",   32'(count4),    32'(m_cnt4));
  end

  initial begin
    reset_n = 1'b0; GPIO_OUT = '0; delay_sel = '0; inj_mode = '0; inj_mask = '0;
    inj_len = '0; inj_start = 1'b0; clr_count = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_gpio_in", 32'(gpio_in16), 32'h0);
    check("reset_busy",    32'(busy16),    32'h0);
    check("reset_count",   32'(count16),   32'h0);

    // 1: first-pass latency at delay 1
    reset_n = 1'b1; GPIO_OUT = 17'h0A5A5; delay_sel = 3'd1;
    #1 check("t1_before_edge", 32'(gpio_in16), 32'h0);
    @(negedge clk);
    check("t1_after_edge", 32'(gpio_in16), 32'h0A5A5);

    // 2: walking one at delay 3, then delay clamping under random data
    delay_sel = 3'd3;
    for (int i = 0; i < 17; i++) begin
      GPIO_OUT = 17'(1) << i;
      @(negedge clk);
    end
    for (int i = 0; i < 40; i++) begin
      GPIO_OUT  = 17'($urandom);
      delay_sel = (i < 20) ? 3'd0 : 3'd7;
      @(negedge clk);
    end

    // 3: one-shot
    GPIO_OUT = 17'h01234; delay_sel = 3'd1; clr_count = 1'b1;
    @(negedge clk);
    clr_count = 1'b0; inj_mode = 2'd1; inj_mask = 17'h10000; inj_start = 1'b1;
    @(negedge clk);
    inj_start = 1'b0;
    check("t3_corrupt", 32'(gpio_in16), 32'h11234);
    check("t3_busy",    32'(busy16),    32'h1);
    @(negedge clk);
    check("t3_clean", 32'(gpio_in16), 32'h01234);
    check("t3_idle",  32'(busy16),    32'h0);
    check("t3_count", 32'(count16),   32'h1);

    // 4: burst of 5 with a restart attempt mid-burst, then zero length
    clr_count = 1'b1;
    @(negedge clk);
    clr_count = 1'b0; inj_mode = 2'd2; inj_len = 8'd5; inj_mask = 17'h000FF; inj_start = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      inj_start = (i == 3);
      check("t4_busy",    32'(busy16),    32'h1);
      check("t4_corrupt", 32'(gpio_in16), 32'h012CB);
    end
    @(negedge clk);
    inj_start = 1'b0;
    check("t4_idle",  32'(busy16),  32'h0);
    check("t4_count", 32'(count16), 32'h5);
    inj_len = 8'd0; inj_start = 1'b1;
    @(negedge clk);
    inj_start = 1'b0;
    check("t4_len0_busy", 32'(busy16), 32'h1);
    @(negedge clk);
    check("t4_len0_idle", 32'(busy16), 32'h0);

    // 5: continuous for 10 cycles, abort, then clear colliding with an increment
    clr_count = 1'b1;
    @(negedge clk);
    clr_count = 1'b0; inj_mode = 2'd3; inj_mask = 17'h1FFFF; inj_start = 1'b1;
    @(negedge clk);
    inj_start = 1'b0;
    repeat (10) @(negedge clk);
    inj_mode = 2'd0;
    @(negedge clk);
    check("t5_idle",  32'(busy16),  32'h0);
    check("t5_count", 32'(count16), 32'd11);
    inj_mode = 2'd3; inj_start = 1'b1;
    @(negedge clk);
    inj_start = 1'b0;
    @(negedge clk);
    clr_count = 1'b1;
    @(negedge clk);
    clr_count = 1'b0;
    check("t5_clr_wins", 32'(count16), 32'h0);
    inj_mode = 2'd0;
    @(negedge clk);

    // 6: reset mid-burst, then 4-bit counter saturation
    inj_mode = 2'd2; inj_len = 8'd20; inj_mask = 17'h000FF; inj_start = 1'b1;
    @(negedge clk);
    inj_start = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("t6_reset_gpio_in", 32'(gpio_in16), 32'h0);
    check("t6_reset_busy",    32'(busy16),    32'h0);
    @(negedge clk);
    reset_n = 1'b1; inj_mode = 2'd3; inj_mask = 17'h00001; inj_start = 1'b1;
    @(negedge clk);
    inj_start = 1'b0;
    repeat (20) @(negedge clk);
    check("t6_sat_c4",  32'(count4),  32'hF);
    check("t6_count20", 32'(count16), 32'd20);
    inj_mode = 2'd0;
    @(negedge clk);

    // randomized traffic, including occasional resets
    for (int i = 0; i < 400; i++) begin
      reset_n   = ($urandom_range(0, 99) != 0);
      GPIO_OUT  = 17'($urandom);
      delay_sel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) inj_mode = 2'($urandom_range(0, 3));
      inj_start = ($urandom_range(0, 5) == 0);
      inj_mask  = ($urandom_range(0, 3) == 0) ? 17'h0 : 17'($urandom);
      inj_len   = 8'($urandom_range(0, 6));
      clr_count = ($urandom_range(0, 30) == 0);
      @(negedge clk);
    end
    reset_n = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
